// File: rtl/core_pkg.sv
// Shared core definitions: register-address width, x0 and the hazard FSM encoding.
package core_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    // Hazard controller states (legacy-compatible constant encoding)
    localparam int unsigned HZ_STATE_W = 2;
    typedef logic [HZ_STATE_W-1:0] hz_state_t;
    localparam hz_state_t HZ_IDLE        = 2'd0;
    localparam hz_state_t HZ_MEM_WAIT    = 2'd1;
    localparam hz_state_t HZ_LOAD_BUBBLE = 2'd2;

endpackage

// File: rtl/hazard_load_use_cmp.sv
// Combinational load-use detector; shared with the forwarding unit.
// A load writing x0 never creates a dependency.
module hazard_load_use_cmp
    import core_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic                  idUsesRs1,
    input  logic                  idUsesRs2,
    input  logic [REG_ADDR_W-1:0] exRd,
    input  logic                  exMemRead,
    output logic                  loadUse
);

    // Flag an ID source that depends on the load currently in EX
    always_comb begin
        loadUse = exMemRead && (exRd != X0) &&
                  ((idUsesRs1 && (idRs1 == exRd)) || (idUsesRs2 && (idRs2 == exRd)));
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard/stall controller for the 5-stage core.
// Priority: data-memory freeze > taken-branch flush > load-use bubble.
// Optional performance counters are enabled with the HAZ_PERF_CNT_EN macro.
module hazard_ctrl_unit
    import core_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic                  idUsesRs1,
    input  logic                  idUsesRs2,
    input  logic [REG_ADDR_W-1:0] exRd,
    input  logic                  exMemRead,
    input  logic                  exBranchTaken,
    input  logic                  memReq,
    input  logic                  memReady,
    output logic                  pcWrite,
    output logic                  ifIdWrite,
    output logic                  ifIdFlush,
    output logic                  idExWrite,
    output logic                  idExFlush,
    output logic                  exMemWrite,
    output logic                  memErr
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stallCycles,
    output logic [CNT_W-1:0]      flushEvents,
    output logic [CNT_W-1:0]      bubbleEvents
`endif
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t         state;
    hz_state_t         stateNext;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitCntNext;
    logic              memErrNext;
    logic              loadUse;
    logic              freeze;
    logic              branchFlush;
    logic              bubbleIns;

    hazard_load_use_cmp u_load_use_cmp (
        .idRs1     (idRs1),
        .idRs2     (idRs2),
        .idUsesRs1 (idUsesRs1),
        .idUsesRs2 (idUsesRs2),
        .exRd      (exRd),
        .exMemRead (exMemRead),
        .loadUse   (loadUse)
    );

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HZ_IDLE;
            waitCnt <= '0;
            memErr  <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            memErr  <= memErrNext;
        end
    end

    // Next-state and same-cycle control outputs, highest-priority hazard first
    always_comb begin
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        ifIdFlush   = 1'b0;
        idExWrite   = 1'b1;
        idExFlush   = 1'b0;
        exMemWrite  = 1'b1;
        stateNext   = HZ_IDLE;
        waitCntNext = '0;
        memErrNext  = memErr;
        freeze      = memReq && !memReady;
        branchFlush = 1'b0;
        bubbleIns   = 1'b0;

        if (freeze) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            stateNext  = HZ_MEM_WAIT;
            waitCntNext = (waitCnt == WAIT_W'(MEM_TIMEOUT)) ? waitCnt : waitCnt + WAIT_W'(1);
            if (waitCnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                memErrNext = 1'b1;
            end
        end else if (exBranchTaken) begin
            // ID instruction is squashed, so any load-use on it is moot
            ifIdFlush   = 1'b1;
            idExFlush   = 1'b1;
            branchFlush = 1'b1;
        end else if (loadUse && (state == HZ_IDLE)) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExFlush = 1'b1;
            stateNext = HZ_LOAD_BUBBLE;
            bubbleIns = 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCycles  <= '0;
            flushEvents  <= '0;
            bubbleEvents <= '0;
        end else begin
            if (freeze && (stallCycles != '1)) begin
                stallCycles <= stallCycles + CNT_W'(1);
            end
            if (branchFlush && (flushEvents != '1)) begin
                flushEvents <= flushEvents + CNT_W'(1);
            end
            if (bubbleIns && (bubbleEvents != '1)) begin
                bubbleEvents <= bubbleEvents + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: stimulus table plus hand-written
// multi-cycle sequences, checked through an expected-value queue.
module tb_hazard_ctrl_unit;
    import core_pkg::*;

    localparam int unsigned MEM_TIMEOUT = 64;

    // Output vector order: {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memErr}
    localparam logic [6:0] DEF = 7'b1101010;
    localparam logic [6:0] STL = 7'b0001110;
    localparam logic [6:0] FLS = 7'b1111110;
    localparam logic [6:0] FRZ = 7'b0000000;
    localparam logic [6:0] ERR = 7'b0000001;

    // ctl = {idUsesRs1, idUsesRs2, exMemRead, exBranchTaken, memReq, memReady}
    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [5:0] ctl;
        logic [6:0] exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] idRs1;
    logic [4:0] idRs2;
    logic       idUsesRs1;
    logic       idUsesRs2;
    logic [4:0] exRd;
    logic       exMemRead;
    logic       exBranchTaken;
    logic       memReq;
    logic       memReady;
    logic       pcWrite;
    logic       ifIdWrite;
    logic       ifIdFlush;
    logic       idExWrite;
    logic       idExFlush;
    logic       exMemWrite;
    logic       memErr;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stallCycles;
    logic [15:0] flushEvents;
    logic [15:0] bubbleEvents;
`endif

    int n_vec = 0;
    int n_bad = 0;
    logic [6:0] sb_q[$];
    vec_t tbl[$];

    hazard_ctrl_unit #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .idRs1         (idRs1),
        .idRs2         (idRs2),
        .idUsesRs1     (idUsesRs1),
        .idUsesRs2     (idUsesRs2),
        .exRd          (exRd),
        .exMemRead     (exMemRead),
        .exBranchTaken (exBranchTaken),
        .memReq        (memReq),
        .memReady      (memReady),
        .pcWrite       (pcWrite),
        .ifIdWrite     (ifIdWrite),
        .ifIdFlush     (ifIdFlush),
        .idExWrite     (idExWrite),
        .idExFlush     (idExFlush),
        .exMemWrite    (exMemWrite),
        .memErr        (memErr)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stallCycles   (stallCycles),
        .flushEvents   (flushEvents),
        .bubbleEvents  (bubbleEvents)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [5:0] ctl, input logic [6:0] exp);
        vec_t v;
        v.rs1 = rs1;
        v.rs2 = rs2;
        v.rd  = rd;
        v.ctl = ctl;
        v.exp = exp;
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memErr};
    endfunction

    task automatic check(input string nm, input logic [6:0] got, input logic [6:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (pc,ifw,iff,idw,idf,exw,err)", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        idRs1 = v.rs1;
        idRs2 = v.rs2;
        exRd  = v.rd;
        {idUsesRs1, idUsesRs2, exMemRead, exBranchTaken, memReq, memReady} = v.ctl;
        sb_q.push_back(v.exp);
    endtask

    // Sample mid-cycle, compare against the queued expectation, then advance one clock
    task automatic step(input vec_t v, input string nm);
        logic [6:0] exp;
        drive(v);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            exp = sb_q.pop_front();
            check(nm, outs(), exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(mk(5'd0, 5'd0, 5'd0, 6'b000000, DEF));
        void'(sb_q.pop_front());
        #3;
        check("reset_default", outs(), DEF);

        // Sequential table: each entry depends on the state left by the previous one
        tbl.push_back(mk(5'd0,  5'd0,  5'd0,  6'b000000, DEF)); // idle
        tbl.push_back(mk(5'd5,  5'd0,  5'd5,  6'b101000, STL)); // load-use rs1
        tbl.push_back(mk(5'd5,  5'd0,  5'd5,  6'b100000, DEF)); // bubble cycle, exMemRead=0
        tbl.push_back(mk(5'd0,  5'd0,  5'd0,  6'b011000, DEF)); // load to x0
        tbl.push_back(mk(5'd0,  5'd7,  5'd7,  6'b011000, STL)); // load-use rs2
        tbl.push_back(mk(5'd0,  5'd7,  5'd7,  6'b011000, DEF)); // only one bubble
        tbl.push_back(mk(5'd9,  5'd0,  5'd9,  6'b001000, DEF)); // match but rs1 unused
        tbl.push_back(mk(5'd5,  5'd0,  5'd5,  6'b101100, FLS)); // branch beats load-use
        tbl.push_back(mk(5'd5,  5'd0,  5'd5,  6'b101110, FRZ)); // freeze beats everything
        tbl.push_back(mk(5'd0,  5'd0,  5'd0,  6'b000010, FRZ)); // still frozen
        tbl.push_back(mk(5'd0,  5'd0,  5'd0,  6'b000011, DEF)); // release
        tbl.push_back(mk(5'd0,  5'd0,  5'd0,  6'b000011, DEF)); // ready access, no freeze
        tbl.push_back(mk(5'd3,  5'd0,  5'd3,  6'b101000, STL)); // load-use
        tbl.push_back(mk(5'd3,  5'd0,  5'd3,  6'b101010, FRZ)); // freeze in bubble
        tbl.push_back(mk(5'd0,  5'd0,  5'd0,  6'b000011, DEF)); // release
        tbl.push_back(mk(5'd3,  5'd0,  5'd3,  6'b101000, STL)); // back in IDLE: stalls again
        tbl.push_back(mk(5'd0,  5'd0,  5'd0,  6'b000100, FLS)); // branch from bubble state
        tbl.push_back(mk(5'd31, 5'd31, 5'd31, 6'b111000, STL)); // both sources hit
        tbl.push_back(mk(5'd0,  5'd0,  5'd0,  6'b000000, DEF));

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Three-cycle memory wait, then release with no error
        for (int k = 1; k <= 3; k++) begin
            step(mk(5'd0, 5'd0, 5'd0, 6'b000010, FRZ), $sformatf("wait3_c%0d", k));
        end
        step(mk(5'd0, 5'd0, 5'd0, 6'b000011, DEF), "wait3_release");
        step(mk(5'd0, 5'd0, 5'd0, 6'b000000, DEF), "wait3_after");

        // Timeout: memErr rises after the 64th frozen cycle and is sticky
        for (int k = 1; k <= 70; k++) begin
            step(mk(5'd0, 5'd0, 5'd0, 6'b000010, (k > MEM_TIMEOUT) ? ERR : FRZ),
                 $sformatf("timeout_c%0d", k));
        end
        step(mk(5'd0, 5'd0, 5'd0, 6'b000011, DEF | ERR), "timeout_release");
        for (int k = 0; k < 3; k++) begin
            step(mk(5'd0, 5'd0, 5'd0, 6'b000000, DEF | ERR), $sformatf("err_sticky%0d", k));
        end

        // Async reset in the second frozen cycle clears memErr without a clock edge
        step(mk(5'd0, 5'd0, 5'd0, 6'b000010, FRZ | ERR), "rstfrz_c1");
        drive(mk(5'd0, 5'd0, 5'd0, 6'b000010, FRZ | ERR));
        void'(sb_q.pop_front());
        #2;
        rst_n = 1'b0;
        memReq = 1'b0;
        #1;
        check("async_reset", outs(), DEF);
`ifdef HAZ_PERF_CNT_EN
        n_vec++;
        if ((stallCycles | flushEvents | bubbleEvents) !== 16'd0) begin
            n_bad++;
            $display("FAIL perf_reset: got %0d/%0d/%0d expected 0/0/0",
                     stallCycles, flushEvents, bubbleEvents);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(mk(5'd6, 5'd0, 5'd6, 6'b101000, STL), "post_reset_idle");
        step(mk(5'd0, 5'd0, 5'd0, 6'b000000, DEF), "post_reset_default");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Pipeline hazard and stall controller for the 5-stage RISC-V core. It consumes the ID-stage source registers and the EX-stage destination and control fields, i.e. the register fields the ID/EX pipeline register hands downstream. It drives the write-enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves three hazard classes, with data-memory wait freezes taking priority over taken-branch flushes, and taken-branch flushes taking priority over load-use bubbles.

Parameters:
MEM_TIMEOUT, 64, cycles a MEM freeze may last before memErr is raised
CNT_W, 16, width of the performance counters (optional feature only)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
idRs1  input  5  rs1 of the instruction in ID
idRs2  input  5  rs2 of the instruction in ID
idUsesRs1  input  1  ID instruction reads rs1
idUsesRs2  input  1  ID instruction reads rs2
exRd  input  5  rd of the instruction in EX
exMemRead  input  1  EX instruction is a load
exBranchTaken  input  1  branch/jump in EX resolved taken
memReq  input  1  MEM stage has an active data-memory access
memReady  input  1  data memory completes the access this cycle
pcWrite  output  1  PC update enable
ifIdWrite  output  1  IF/ID write enable
ifIdFlush  output  1  IF/ID clear to NOP
idExWrite  output  1  ID/EX write enable
idExFlush  output  1  ID/EX clear to bubble
exMemWrite  output  1  EX/MEM write enable
memErr  output  1  sticky: MEM freeze exceeded MEM_TIMEOUT

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, waitCnt=0, memErr=0.
  - Control outputs follow the IDLE rules below.
- Registered state: IDLE, MEM_WAIT, LOAD_BUBBLE. Control outputs are combinational from the state and the current inputs. There is no extra latency.
- Default (no hazard):
  - pcWrite, ifIdWrite, idExWrite and exMemWrite are 1.
  - ifIdFlush and idExFlush are 0.
- loadUse condition:
  - exMemRead && exRd!=0 && ((idUsesRs1 && idRs1==exRd) || (idUsesRs2 && idRs2==exRd)).
  - x0 never causes a hazard.
- Priority 1, freeze (memReq && !memReady, in any state):
  - pcWrite, ifIdWrite, idExWrite and exMemWrite are 0.
  - Both flushes are 0.
  - The state enters or stays in MEM_WAIT.
  - waitCnt increments and saturates at MEM_TIMEOUT.
  - When waitCnt==MEM_TIMEOUT-1 and the wait continues, memErr is set. memErr is cleared only by reset.
- MEM_WAIT exit: on the cycle memReady=1, the freeze releases that same cycle (default enables), waitCnt returns to 0, and the state returns to IDLE.
- Priority 2, taken branch (exBranchTaken, not frozen):
  - ifIdFlush=1 and idExFlush=1; the write enables stay 1.
  - Two-cycle penalty.
  - Any concurrent loadUse is ignored because the ID instruction is squashed.
  - The state goes to IDLE.
- Priority 3, load-use (loadUse, not frozen, not taken branch, state IDLE):
  - pcWrite=0, ifIdWrite=0, idExFlush=1.
  - The state goes to LOAD_BUBBLE.
- LOAD_BUBBLE:
  - Exactly one bubble is inserted.
  - The next unfrozen cycle returns to default outputs and IDLE, even if loadUse evaluates true again. In that cycle exMemRead is the bubble's 0, so it cannot.
  - A freeze arriving in LOAD_BUBBLE takes priority. After the freeze releases, the state is IDLE.
- Reset mid-freeze or mid-bubble: the state returns to IDLE at once and outputs go to default.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds output ports stallCycles, flushEvents and bubbleEvents, each CNT_W wide.
  - stallCycles increments on every freeze cycle.
  - flushEvents increments on every taken-branch flush cycle.
  - bubbleEvents increments on every load-use bubble insertion.
  - All three saturate at all-ones and reset to 0.
- Undefined: the ports and the logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg holds:
  - the hazard state enum (IDLE/MEM_WAIT/LOAD_BUBBLE);
  - REG_ADDR_W=5;
  - the X0 constant.
- One sub-module, hazard_load_use_cmp: the purely combinational loadUse comparator. It is reused by the forwarding unit.
- The FSM and counters stay in the top level.

Test Plan:
- Load-use: exMemRead=1, exRd=5, idRs1=5, idUsesRs1=1 -> one cycle with pcWrite=0, ifIdWrite=0, idExFlush=1; the next cycle (exMemRead=0) returns to default.
- x0 load: exMemRead=1, exRd=0, idRs2=0, idUsesRs2=1 -> no stall; outputs stay default.
- Branch plus load-use in the same cycle: exBranchTaken=1 and the loadUse condition true -> ifIdFlush=1, idExFlush=1, pcWrite=1.
- Memory wait: memReq=1, memReady=0 for 3 cycles, then 1 -> all enables 0 for 3 cycles, released on cycle 4, memErr stays 0.
- Timeout: memReq=1, memReady=0 for 70 cycles with MEM_TIMEOUT=64 -> memErr rises after 64 cycles and stays 1 after release until reset.
- Async reset: assert rst_n=0 mid-freeze (cycle 2), release -> outputs default immediately, state IDLE, memErr=0; with HAZ_PERF_CNT_EN defined, all counters read 0.
